ahb_lite_cmd_master: RTL and testbench
======================================

Name: ahb_lite_cmd_master

Overview:
- Command-driven AHB-Lite initiator that feeds a slave port of the Level-1 bus matrix.
- Converts simple commands (read/write, start address, 1-16 words) into 32-bit SINGLE/INCR bursts with full pipelining.
- Handles wait states, write-data underrun via BUSY, and two-cycle ERROR responses, such as those from the matrix default slave.
- Used by test/boot engines that need bus access without a CPU.

Parameters:
HPROT_VAL, 4'b0011, constant HPROT value (data, privileged, non-bufferable).

Ports:
HCLK  in  1  AHB system clock
HRESET  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  block idle, command accepted when both high
cmd_write  in  1  1=write, 0=read
cmd_addr  in  32  start byte address; bits [1:0] ignored (forced 00)
cmd_len  in  4  beats-1 (0 = 1 beat, 15 = 16 beats)
wr_valid  in  1  write word available
wr_ready  out  1  write word consumed this cycle
wr_data  in  32  write word
rd_valid  out  1  read word valid (single-cycle, no backpressure)
rd_data  out  32  read word
done_valid  out  1  one-cycle command-complete pulse
done_err  out  1  qualifies done_valid; 1 = ERROR received or command rejected
HADDR  out  32  address
HTRANS  out  2  IDLE/BUSY/NONSEQ/SEQ
HWRITE  out  1  direction
HSIZE  out  3  fixed 3'b010
HBURST  out  3  000 SINGLE if cmd_len==0, else 001 INCR
HPROT  out  4  HPROT_VAL
HMASTLOCK  out  1  fixed 0
HWDATA  out  32  write data
HRDATA  in  32  read data
HREADY  in  1  transfer done
HRESP  in  2  bit0 = ERROR

Behaviour:
- Reset, synchronous on HCLK while HRESET=1:
  - State IDLE; HTRANS=00; HADDR, HWDATA, rd_data = 0; HWRITE=0; HBURST=000.
  - rd_valid, done_valid, done_err, wr_ready = 0; cmd_ready=0 during reset, 1 the cycle after.
  - Reset mid-burst abandons the burst immediately; no done pulse.
- States:
  - IDLE: cmd_ready=1.
  - ADDR: issuing beats.
  - DRAIN: final data phase pending.
  - ERR2: second ERROR cycle.
  - DONE: one cycle, done_valid=1.
- IDLE->ADDR on cmd_valid&cmd_ready. Command fields are registered; the bus sees the first beat the next cycle at the earliest.
- All AHB outputs are registered. Address-phase outputs (HADDR, HTRANS, HWRITE, HBURST) change only on cycles where HREADY=1, except the ERROR cancel below.
- Beat issue:
  - Read: every HREADY=1 cycle until cmd_len+1 beats are issued.
  - Write: only when wr_valid=1. wr_ready pulses that cycle and wr_data is latched into a holding register. HWDATA loads from the holding register when that beat's address phase completes (HREADY=1).
- HTRANS encoding:
  - First beat: NONSEQ.
  - Later beats: SEQ, HADDR += 4.
  - Write underrun mid-burst: BUSY with HADDR held at the next address.
  - Underrun before the first beat: IDLE.
- After the last address phase completes: HTRANS=IDLE, state DRAIN.
- Read data: on each completed read data phase (HREADY=1, HRESP[0]=0), rd_valid=1 with rd_data=HRDATA in the following cycle.
- Data phase completion: DRAIN->DONE when the last data phase completes with OKAY. DONE->IDLE after one cycle. cmd_ready rises the cycle after done_valid.
- ERROR handling:
  - First cycle (HREADY=0, HRESP[0]=1): next HTRANS=IDLE, cancelling any pending address phase; stop issuing; go to ERR2.
  - ERR2 ends on HREADY=1, then DONE with done_err=1.
  - No rd_valid for the errored beat or any later beat.
  - A write burst does not pop further wr_data.
- Wait states: HREADY=0 holds every AHB output and suspends beat counting.
- 1KB boundary: a command whose final beat address [31:10] differs from the start address [31:10] crosses 1KB. Handling depends on the optional feature below.

Optional Feature:
- Macro: AHB_MST_1KB_SPLIT_EN.
- Defined: a crossing command is split. The beat at the boundary is issued NONSEQ (HBURST=INCR unchanged) and the burst continues. One done pulse covers the whole command.
- Undefined: a crossing command is rejected:
  - IDLE->DONE with done_err=1 two cycles after acceptance.
  - No bus activity (HTRANS stays IDLE) and wr_ready never pulses.

Test Plan:
- Read 0x20000000, len 0, zero-wait slave returning 0xA5A5_0001 -> HTRANS NONSEQ, HBURST 000; rd_valid with 0xA5A5_0001; done_valid, done_err=0.
- Write 0x40000010, len 3, data 1..4, slave inserts 2 wait states on beat 2 -> HADDR 0x10/0x14/0x18/0x1C held during waits; NONSEQ,SEQ,SEQ,SEQ; HWDATA 1..4; done_err=0.
- Write len 3 with wr_valid low for 2 cycles after beat 1 -> two BUSY cycles at HADDR base+4, then SEQ continues; 4 wr_ready pulses total.
- Read 0x30000000 (unmapped, default slave ERROR), len 3 -> HTRANS goes IDLE in ERR cycle 1; zero rd_valid; done_valid with done_err=1; cmd_ready high next cycle.
- Read 0x200003F8, len 3 -> with macro: addresses 3F8,3FC NONSEQ/SEQ then 400 NONSEQ, 404 SEQ, done_err=0; without macro: no bus transfer, done_err=1.
- HRESET asserted during beat 3 of a 16-beat write -> next cycle HTRANS=IDLE, wr_ready=0, no done_valid; new command accepted after release.

Source files
------------

// File: rtl/ahb_lite_cmd_master.sv
// Command-driven AHB-Lite initiator: turns read/write commands of 1-16 words into SINGLE/INCR bursts.
// Define AHB_MST_1KB_SPLIT_EN to split 1KB-crossing commands; otherwise they are rejected with an error.
module ahb_lite_cmd_master #(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_len,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        done_valid,
    output logic        done_err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic [1:0]  HRESP
);
    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DRAIN, S_ERR2, S_DONE} state_t;
    state_t r_state, w_next;

    logic [31:0] r_addr;
    logic [31:0] r_wbuf;
    logic [4:0]  r_left;
    logic        r_first, r_write, r_single, r_reject, r_err;
    logic        r_dp_valid, r_dp_write;
    logic        w_accept, w_err1, w_can, w_issue, w_last, w_bnd, w_rej;
    logic        w_unused;

`ifdef AHB_MST_1KB_SPLIT_EN
    assign w_bnd = (r_addr[9:0] == 10'd0);
    assign w_rej = 1'b0;
`else
    logic [31:0] w_last_addr;
    assign w_last_addr = {cmd_addr[31:2], 2'b00} + {26'd0, cmd_len, 2'b00};
    assign w_bnd = 1'b0;
    assign w_rej = (w_last_addr[31:10] != cmd_addr[31:10]);
`endif

    assign w_unused  = ^{HRESP[1], cmd_addr[1:0]};

    assign HSIZE     = 3'b010;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;

    assign cmd_ready  = (r_state == S_IDLE) && !HRESET;
    assign w_accept   = cmd_valid && cmd_ready;
    // First ERROR cycle of the data phase currently in flight
    assign w_err1     = (r_state == S_ADDR || r_state == S_DRAIN) && r_dp_valid && !HREADY && HRESP[0];
    assign w_can      = (r_state == S_ADDR) && !r_reject && HREADY && (r_left != 5'd0);
    assign w_issue    = w_can && (!r_write || wr_valid);
    assign w_last     = (r_state == S_ADDR) && !r_reject && HREADY && (r_left == 5'd0);
    assign wr_ready   = w_issue && r_write && !HRESET;
    assign done_valid = (r_state == S_DONE) && !HRESET;
    assign done_err   = done_valid && r_err;

    always_ff @(posedge HCLK) begin
        if (HRESET) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ADDR;
            S_ADDR: begin
                if (r_reject)    w_next = S_DONE;
                else if (w_err1) w_next = S_ERR2;
                else if (w_last) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_err1)      w_next = S_ERR2;
                else if (HREADY) w_next = S_DONE;
            end
            S_ERR2:  if (HREADY) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            HADDR      <= 32'd0;
            HTRANS     <= T_IDLE;
            HWRITE     <= 1'b0;
            HBURST     <= 3'b000;
            HWDATA     <= 32'd0;
            rd_valid   <= 1'b0;
            rd_data    <= 32'd0;
            r_addr     <= 32'd0;
            r_wbuf     <= 32'd0;
            r_left     <= 5'd0;
            r_first    <= 1'b0;
            r_write    <= 1'b0;
            r_single   <= 1'b0;
            r_reject   <= 1'b0;
            r_err      <= 1'b0;
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
        end else begin
            rd_valid <= HREADY && r_dp_valid && !r_dp_write && !HRESP[0];
            if (HREADY && r_dp_valid && !r_dp_write && !HRESP[0]) rd_data <= HRDATA;
            if (HREADY && r_dp_valid && HRESP[0]) r_err <= 1'b1;

            // Track which data phase starts as each address phase completes
            if (HREADY) begin
                r_dp_valid <= HTRANS[1];
                r_dp_write <= HWRITE;
                if (HTRANS[1] && HWRITE) HWDATA <= r_wbuf;
            end

            if (w_accept) begin
                r_addr   <= {cmd_addr[31:2], 2'b00};
                r_left   <= {1'b0, cmd_len} + 5'd1;
                r_first  <= 1'b1;
                r_write  <= cmd_write;
                r_single <= (cmd_len == 4'd0);
                r_reject <= w_rej;
                r_err    <= w_rej;
            end

            if (w_issue) begin
                HTRANS  <= (r_first || w_bnd) ? T_NSEQ : T_SEQ;
                HADDR   <= r_addr;
                HWRITE  <= r_write;
                HBURST  <= r_single ? 3'b000 : 3'b001;
                r_addr  <= r_addr + 32'd4;
                r_left  <= r_left - 5'd1;
                r_first <= 1'b0;
                if (r_write) r_wbuf <= wr_data;
            end else if (w_can) begin
                // Write underrun: nothing on the bus yet, or BUSY parked on the next beat address
                HTRANS <= r_first ? T_IDLE : T_BUSY;
                if (!r_first) HADDR <= r_addr;
            end else if (w_last) begin
                HTRANS <= T_IDLE;
            end

            if (w_err1) begin
                HTRANS <= T_IDLE;
                r_err  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Randomized scoreboard bench for ahb_lite_cmd_master with a behavioural AHB slave and command-level model.
module tb_ahb_lite_cmd_master;
`ifdef AHB_MST_1KB_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif
    localparam logic [31:0] MAGIC = 32'h85A5_0001;

    logic        HCLK = 1'b0, HRESET = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [3:0]  cmd_len = '0;
    logic        wr_valid = 1'b0, wr_ready;
    logic [31:0] wr_data = '0;
    logic        rd_valid, done_valid, done_err;
    logic [31:0] rd_data, HADDR, HWDATA;
    logic [31:0] HRDATA = '0;
    logic [1:0]  HTRANS;
    logic        HWRITE, HMASTLOCK;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic        HREADY = 1'b1;
    logic [1:0]  HRESP = 2'b00;

    ahb_lite_cmd_master dut (
        .HCLK(HCLK), .HRESET(HRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .done_valid(done_valid), .done_err(done_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct { logic [31:0] a; logic w; logic [1:0] t; logic [2:0] b; } beat_t;
    typedef struct { logic [31:0] a; logic [31:0] d; } wbeat_t;

    beat_t       exp_addr_q[$];
    wbeat_t      exp_wr_q[$];
    logic [31:0] exp_rd_q[$];
    logic        exp_done_q[$];
    logic [31:0] wd_q[$];
    int          wait_q[$];
    int          gap_q[$];
    logic [31:0] mdl  [logic [31:0]];
    logic [31:0] smem [logic [31:0]];

    int n_chk = 0, n_fail = 0;
    bit chk_en = 1'b1;
    int max_wait = 0;
    bit rnd_gap = 1'b0;
    int wr_pops = 0, busy_cnt = 0, beat_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Write-data source with optional underrun gaps
    int gap_cnt = 0;
    always @(posedge HCLK) begin
        if (wr_valid && wr_ready && wd_q.size() > 0) begin
            void'(wd_q.pop_front());
            wr_pops++;
            if (gap_q.size() > 0) gap_cnt = gap_q.pop_front();
            else gap_cnt = (rnd_gap && ($urandom % 3 == 0)) ? int'($urandom % 3) : 0;
        end else if (gap_cnt > 0) begin
            gap_cnt--;
        end
        #1;
        wr_valid = (wd_q.size() > 0) && (gap_cnt == 0);
        wr_data  = (wd_q.size() > 0) ? wd_q[0] : 32'd0;
    end

    // AHB slave: region 0x3xxxxxxx answers ERROR, elsewhere memory with random wait states
    bit          s_dp = 0, s_dp_w = 0, s_dp_e = 0;
    logic [31:0] s_dp_a = '0;
    int          s_wait = 0, s_err_st = 0;
    logic        prev_rdy = 1'b1, prev_resp = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [1:0]  prev_trans = '0;
    always @(posedge HCLK) begin
        logic        n_rdy, n_resp;
        logic [31:0] n_rd;
        wbeat_t      wb;
        beat_t       bt;
        if (HRESET) begin
            s_dp = 0; s_err_st = 0; prev_rdy = 1'b1; prev_resp = 1'b0;
            #1;
            HREADY = 1'b1; HRESP = 2'b00;
        end else begin
            if (chk_en && !prev_rdy && !prev_resp) begin
                chk("hold_haddr", HADDR, prev_addr);
                chk("hold_htrans", {30'd0, HTRANS}, {30'd0, prev_trans});
            end
            prev_rdy = HREADY; prev_resp = HRESP[0]; prev_addr = HADDR; prev_trans = HTRANS;
            if (s_err_st == 2 && chk_en) chk("htrans_idle_in_err2", {30'd0, HTRANS}, 32'd0);
            if (HREADY && s_dp && s_dp_w && !s_dp_e) begin
                smem[s_dp_a] = HWDATA;
                if (chk_en) begin
                    if (exp_wr_q.size() == 0) chk("unexpected_write", s_dp_a, 32'hFFFF_FFFF);
                    else begin
                        wb = exp_wr_q.pop_front();
                        chk("write_addr", s_dp_a, wb.a);
                        chk("hwdata", HWDATA, wb.d);
                    end
                end
            end
            if (HREADY) begin
                if (HTRANS == 2'b01 && chk_en) begin
                    busy_cnt++;
                    if (exp_addr_q.size() > 0) chk("busy_haddr", HADDR, exp_addr_q[0].a);
                    else chk("busy_without_beats", {30'd0, HTRANS}, 32'd0);
                end
                s_dp = HTRANS[1]; s_dp_a = HADDR; s_dp_w = HWRITE;
                s_dp_e = (HADDR[31:28] == 4'h3); s_err_st = 0;
                if (HTRANS[1]) begin
                    beat_cnt++;
                    s_wait = (wait_q.size() > 0) ? wait_q.pop_front() : int'($urandom_range(0, max_wait));
                    if (chk_en) begin
                        if (exp_addr_q.size() == 0) chk("unexpected_beat", HADDR, 32'hFFFF_FFFF);
                        else begin
                            bt = exp_addr_q.pop_front();
                            chk("haddr", HADDR, bt.a);
                            chk("htrans", {30'd0, HTRANS}, {30'd0, bt.t});
                            chk("hwrite", {31'd0, HWRITE}, {31'd0, bt.w});
                            chk("hburst", {29'd0, HBURST}, {29'd0, bt.b});
                        end
                    end
                end
            end
            n_rdy = 1'b1; n_resp = 1'b0; n_rd = HRDATA;
            if (s_dp) begin
                if (s_dp_e) begin
                    n_resp = 1'b1;
                    if (s_err_st == 0) begin n_rdy = 1'b0; s_err_st = 1; end
                    else s_err_st = 2;
                end else if (s_wait > 0) begin
                    n_rdy = 1'b0; s_wait--;
                end else if (!s_dp_w) begin
                    n_rd = smem.exists(s_dp_a) ? smem[s_dp_a] : (s_dp_a ^ MAGIC);
                end
            end
            #1;
            HREADY = n_rdy; HRESP = {1'b0, n_resp}; HRDATA = n_rd;
        end
    end

    // Response monitor
    always @(negedge HCLK) begin
        if (rd_valid) begin
            if (exp_rd_q.size() == 0) chk("unexpected_rd_valid", rd_data, 32'hFFFF_FFFF);
            else chk("rd_data", rd_data, exp_rd_q.pop_front());
        end
        if (done_valid) begin
            if (exp_done_q.size() == 0) chk("unexpected_done", {31'd0, done_err}, 32'hFFFF_FFFF);
            else chk("done_err", {31'd0, done_err}, {31'd0, exp_done_q.pop_front()});
        end
    end

    task automatic run_cmd(input bit w, input logic [31:0] a, input logic [3:0] len, input bit seqd);
        logic [31:0] base, lst, ad, d;
        bit rej, err, got;
        int n;
        beat_t bt;
        wbeat_t wb;
        base = {a[31:2], 2'b00};
        lst  = base + 32'(len) * 4;
        rej  = (base[31:10] != lst[31:10]) && !SPLIT;
        err  = (base[31:28] == 4'h3);
        exp_done_q.push_back(rej || err);
        for (int i = 0; i <= int'(len); i++) begin
            ad = base + 32'(i) * 4;
            d  = seqd ? 32'(i + 1) : $urandom;
            if (w) wd_q.push_back(d);
            if (!rej) begin
                if (!err || i == 0) begin
                    bt.a = ad; bt.w = w;
                    bt.t = (i == 0 || (SPLIT && ad[9:0] == 10'd0)) ? 2'b10 : 2'b11;
                    bt.b = (len == 4'd0) ? 3'b000 : 3'b001;
                    exp_addr_q.push_back(bt);
                end
                if (!err) begin
                    if (w) begin
                        wb.a = ad; wb.d = d; exp_wr_q.push_back(wb); mdl[ad] = d;
                    end else begin
                        exp_rd_q.push_back(mdl.exists(ad) ? mdl[ad] : (ad ^ MAGIC));
                    end
                end
            end
        end
        wr_pops = 0;
        @(posedge HCLK); #1;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = len;
        @(negedge HCLK);
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
        got = 1'b0;
        for (n = 1; n <= 500; n++) begin
            @(negedge HCLK);
            if (done_valid) begin got = 1'b1; break; end
        end
        if (!got) begin
            n_chk++; n_fail++;
            $display("FAIL done_timeout: no done_valid within 500 cycles for addr %h", a);
        end else if (rej) begin
            chk("reject_latency", 32'(n), 32'd2);
        end
        @(negedge HCLK);
        chk("cmd_ready_after_done", {31'd0, cmd_ready}, 32'd1);
        chk("rd_left", 32'(exp_rd_q.size()), 32'd0);
        chk("beats_left", 32'(exp_addr_q.size()), 32'd0);
        chk("writes_left", 32'(exp_wr_q.size()), 32'd0);
        if (w && !err) chk("wr_ready_pulses", 32'(wr_pops), rej ? 32'd0 : 32'(len) + 32'd1);
        wd_q.delete(); exp_rd_q.delete(); exp_addr_q.delete(); exp_wr_q.delete();
        exp_done_q.delete(); wait_q.delete(); gap_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        bit          got;
        int          b0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_htrans", {30'd0, HTRANS}, 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_hwrite", {31'd0, HWRITE}, 32'd0);
        chk("rst_hburst", {29'd0, HBURST}, 32'd0);
        chk("rst_outs", {28'd0, rd_valid, done_valid, done_err, wr_ready}, 32'd0);
        chk("hsize", {29'd0, HSIZE}, 32'd2);
        chk("hprot", {28'd0, HPROT}, 32'd3);
        chk("hmastlock", {31'd0, HMASTLOCK}, 32'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("cmd_ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        max_wait = 0;
        run_cmd(1'b0, 32'h2000_0000, 4'd0, 1'b0);
        wait_q = '{0, 2, 0, 0};
        run_cmd(1'b1, 32'h4000_0010, 4'd3, 1'b1);
        run_cmd(1'b0, 32'h4000_0010, 4'd3, 1'b0);
        gap_q = '{2};
        busy_cnt = 0;
        run_cmd(1'b1, 32'h4000_0100, 4'd3, 1'b1);
        chk("busy_cycles", 32'(busy_cnt), 32'd2);
        run_cmd(1'b0, 32'h3000_0000, 4'd3, 1'b0);
        run_cmd(1'b0, 32'h2000_03F8, 4'd3, 1'b0);
        run_cmd(1'b1, 32'h2000_07F2, 4'd7, 1'b0);
        run_cmd(1'b1, 32'h3000_0040, 4'd2, 1'b0);

        // Reset in the middle of a 16-beat write
        chk_en = 1'b0;
        for (int i = 0; i < 16; i++) wd_q.push_back(32'hC000_0000 + 32'(i));
        @(posedge HCLK); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h5000_0000; cmd_len = 4'd15;
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
        b0 = beat_cnt; got = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge HCLK);
            if (beat_cnt - b0 >= 2) begin got = 1'b1; break; end
        end
        if (!got) begin
            n_chk++; n_fail++;
            $display("FAIL reset_test_timeout: beats %0d", beat_cnt - b0);
        end
        HRESET = 1'b1;
        #1;
        chk("wr_ready_in_reset", {31'd0, wr_ready}, 32'd0);
        chk("cmd_ready_in_reset", {31'd0, cmd_ready}, 32'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        wd_q.delete();
        chk("htrans_after_reset", {30'd0, HTRANS}, 32'd0);
        chk("wr_ready_after_reset", {31'd0, wr_ready}, 32'd0);
        repeat (4) begin
            @(negedge HCLK);
            chk("no_done_after_reset", {31'd0, done_valid}, 32'd0);
        end
        chk_en = 1'b1;
        run_cmd(1'b0, 32'h2000_0040, 4'd1, 1'b0);

        // Randomized traffic mixing memory and error regions
        rnd_gap = 1'b1;
        for (int k = 0; k < 40; k++) begin
            max_wait = int'($urandom % 3);
            if ($urandom % 8 == 0) ra = 32'h3000_0000 + (($urandom % 256) * 4);
            else                   ra = 32'h2000_0000 + (($urandom % 512) * 4);
            ra[1:0] = 2'($urandom);
            run_cmd(1'($urandom), ra, 4'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
